display_cmd_arbiter: RTL and testbench
======================================

DISPLAY_CMD_ARBITER -- requirements
Module: display_cmd_arbiter

Interface
REQ-001 Parameter N_REQ, default 4, number of requesters, range 2..8.
REQ-002 Parameter DATA_W, default 48, command payload width.
REQ-003 Parameter TIMEOUT, default 4095, watchdog limit in cycles; used only when the watchdog is compiled in.
REQ-004 clk  input  1  sole clock; all state is updated on its rising edge.
REQ-005 rst  input  1  reset, asynchronous and active-high.
REQ-006 req_valid  input  N_REQ  per-requester command pending.
REQ-007 req_cmd  input  4*N_REQ  per-requester opcode; requester i occupies bits [4i+3:4i].
REQ-008 req_data  input  DATA_W*N_REQ  per-requester payload; requester i occupies bits [DATA_W*i+DATA_W-1:DATA_W*i].
REQ-009 req_ready  output  N_REQ  one-hot acceptance strobe; valid&ready completes a transfer.
REQ-010 disp_cmd  output  4  opcode to the display engine.
REQ-011 disp_data  output  DATA_W  payload to the display engine.
REQ-012 disp_ready  input  1  display engine idle; low within the cycle any nonzero disp_cmd is driven.
REQ-013 busy  output  1  high in every state except IDLE.
REQ-014 grant_id  output  clog2(N_REQ)  index of the last accepted requester.
REQ-015 timeout_err  output  1  sticky watchdog flag.

Function
REQ-016 FSM states SHALL be IDLE, ISSUE, GUARD and WAIT, one-hot encoded.
REQ-017 In IDLE, with disp_ready=1 and any req_valid set, the block SHALL select the winner round-robin, starting at (grant_id+1) mod N_REQ and ascending with wrap.
REQ-018 In that same cycle the block SHALL assert req_ready for the winner only, latch the winner's cmd/data, and update grant_id.
REQ-019 An accepted opcode of 1..3 SHALL move the FSM to ISSUE; opcode 0 or 4..15 SHALL be consumed and dropped, with the FSM staying in IDLE.
REQ-020 ISSUE SHALL drive the latched cmd/data on disp_cmd/disp_data for exactly one cycle, then move to GUARD.
REQ-021 GUARD SHALL drive disp_cmd=0, ignore disp_ready and move to WAIT after one cycle.
REQ-022 WAIT SHALL hold disp_cmd=0 until disp_ready=1, then move to IDLE; no grant SHALL occur in that same cycle.
REQ-023 disp_cmd SHALL be 0 in every state except ISSUE; disp_data SHALL hold its last value outside ISSUE.
REQ-024 Latency: acceptance in cycle T gives a nonzero disp_cmd in T+1. Back-to-back commands are spaced by at least 4 cycles plus the display busy time.
REQ-025 req_ready SHALL never be asserted when disp_ready=0 or the FSM is outside IDLE.
REQ-026 A requester dropping req_valid before acceptance SHALL be treated as a withdrawal, not an error.
REQ-027 grant_id SHALL change only on acceptance, including acceptance of a dropped opcode.

Reset
REQ-028 While rst=1, the block SHALL be in IDLE with req_ready=0, disp_cmd=0, disp_data=0, busy=0, timeout_err=0 and grant_id=N_REQ-1, so requester 0 has first priority.
REQ-029 Reset asserted during ISSUE, GUARD or WAIT SHALL abort the command immediately; the block SHALL not reissue it after release.

Configuration
REQ-030 With macro DISPLAY_ARB_WATCHDOG_EN defined, a counter SHALL clear on entry to WAIT and increment each WAIT cycle. When it reaches TIMEOUT, the FSM SHALL go to IDLE and timeout_err SHALL set; the flag clears only by reset.
REQ-031 Without DISPLAY_ARB_WATCHDOG_EN, WAIT SHALL wait indefinitely, timeout_err SHALL be tied to 0, and no counter logic SHALL be synthesised.

Structure
REQ-032 The shared package display_pkg SHALL hold the opcode constants CMD_NOP=0, CMD_SCROLL=1, CMD_POS_CLEAR=2 and CMD_NUMBER=3, plus the display payload width of 48.
REQ-033 Round-robin selection SHALL reside in a combinational sub-module rr_arbiter with inputs (req, last_grant) and outputs (gnt_onehot, gnt_idx, any).
REQ-034 The FSM, latches and watchdog SHALL reside in display_cmd_arbiter.

Verification
REQ-035 Single request: req0 with cmd=3, data=0x0005_0A_0000002A and disp_ready=1 -> req_ready[0] in T, disp_cmd=3 with that data in T+1 only, busy until disp_ready returns.
REQ-036 Fairness: all four requesters valid with cmd=1 continuously -> grant order 0,1,2,3,0, and every disp_cmd pulse is 1 cycle wide.
REQ-037 Illegal opcode: req2 with cmd=7 -> req_ready[2] pulses, disp_cmd stays 0, FSM stays IDLE, and grant_id=2.
REQ-038 Display busy: disp_ready held 0 for 200 cycles after ISSUE -> no req_ready during that window, and the next grant occurs at least 1 cycle after disp_ready rises.
REQ-039 Reset mid-WAIT: rst pulsed with req1 pending -> outputs at reset values, and after release requester 0 wins over requester 1 when both are valid.
REQ-040 Watchdog (DISPLAY_ARB_WATCHDOG_EN, TIMEOUT=16): disp_ready stuck at 0 -> IDLE after 16 WAIT cycles and timeout_err=1; timeout_err stays 0 for the same stimulus in a build without the macro.

Source files
------------

// File: rtl/display_pkg.sv
// Shared display definitions: opcodes, payload width, arbiter FSM state encoding
// and the opcode legality helper.
package display_pkg;

    localparam int DISP_DATA_W = 48;

    localparam logic [3:0] CMD_NOP       = 4'd0;
    localparam logic [3:0] CMD_SCROLL    = 4'd1;
    localparam logic [3:0] CMD_POS_CLEAR = 4'd2;
    localparam logic [3:0] CMD_NUMBER    = 4'd3;

    typedef enum logic [3:0] {
        ST_IDLE  = 4'b0001,
        ST_ISSUE = 4'b0010,
        ST_GUARD = 4'b0100,
        ST_WAIT  = 4'b1000
    } arb_state_e;

    // Only these opcodes reach the display engine; all others are consumed and dropped.
    function automatic logic cmd_is_issuable(input logic [3:0] cmd);
        logic ok;
        case (cmd)
            CMD_SCROLL, CMD_POS_CLEAR, CMD_NUMBER: ok = 1'b1;
            CMD_NOP:                               ok = 1'b0;
            default:                               ok = 1'b0;
        endcase
        return ok;
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: searches upward from last_grant+1 with wrap
// and returns the first pending requester.
module rr_arbiter #(
    parameter int N     = 4,
    parameter int IDX_W = $clog2(N)
) (
    input  logic [N-1:0]     req,
    input  logic [IDX_W-1:0] last_grant,
    output logic [N-1:0]     gnt_onehot,
    output logic [IDX_W-1:0] gnt_idx,
    output logic             any
);

    int                idx;
    logic [IDX_W-1:0]  sel;
    logic              hit;

    // Priority scan; the first hit freezes the result for the remaining offsets.
    always_comb begin
        gnt_onehot = '0;
        gnt_idx    = '0;
        any        = 1'b0;
        idx        = 0;
        sel        = '0;
        hit        = 1'b0;
        for (int k = 1; k <= N; k++) begin
            idx             = (int'(last_grant) + k) % N;
            sel             = IDX_W'(idx);
            hit             = req[sel] & ~any;
            gnt_onehot[sel] = gnt_onehot[sel] | hit;
            gnt_idx         = hit ? sel : gnt_idx;
            any             = any | hit;
        end
    end

endmodule

// File: rtl/display_cmd_arbiter.sv
// Arbitrates N_REQ command sources onto one display engine (IDLE/ISSUE/GUARD/WAIT).
// Optional WAIT watchdog is compiled in with DISPLAY_ARB_WATCHDOG_EN.
module display_cmd_arbiter
    import display_pkg::*;
#(
    parameter int N_REQ   = 4,
    parameter int DATA_W  = DISP_DATA_W,
    parameter int TIMEOUT = 4095
) (
    input  logic                      clk,
    input  logic                      rst,
    input  logic [N_REQ-1:0]          req_valid,
    input  logic [4*N_REQ-1:0]        req_cmd,
    input  logic [DATA_W*N_REQ-1:0]   req_data,
    output logic [N_REQ-1:0]          req_ready,
    output logic [3:0]                disp_cmd,
    output logic [DATA_W-1:0]         disp_data,
    input  logic                      disp_ready,
    output logic                      busy,
    output logic [$clog2(N_REQ)-1:0]  grant_id,
    output logic                      timeout_err
);

    localparam int IDX_W = $clog2(N_REQ);

    arb_state_e          state_q, state_d;
    logic [3:0]          disp_cmd_q, disp_cmd_d;
    logic [DATA_W-1:0]   disp_data_q, disp_data_d;
    logic [IDX_W-1:0]    grant_q, grant_d;

    logic [N_REQ-1:0]    gnt_onehot_s;
    logic [IDX_W-1:0]    gnt_idx_s;
    logic                any_s;
    logic                accept_s;
    logic [N_REQ-1:0]    req_ready_s;
    logic [3:0]          win_cmd_s;
    logic [DATA_W-1:0]   win_data_s;

`ifdef DISPLAY_ARB_WATCHDOG_EN
    localparam int              WD_W     = $clog2(TIMEOUT + 1);
    localparam logic [WD_W-1:0] WD_LAST  = WD_W'(TIMEOUT - 1);
    logic [WD_W-1:0]            wd_q, wd_d;
    logic                       err_q, err_d;
`endif

    rr_arbiter #(.N(N_REQ), .IDX_W(IDX_W)) u_rr (
        .req        (req_valid),
        .last_grant (grant_q),
        .gnt_onehot (gnt_onehot_s),
        .gnt_idx    (gnt_idx_s),
        .any        (any_s)
    );

    // Winner cmd/data mux driven by the one-hot grant.
    always_comb begin
        win_cmd_s  = 4'd0;
        win_data_s = '0;
        for (int i = 0; i < N_REQ; i++) begin
            win_cmd_s  = win_cmd_s  | (req_cmd[4*i +: 4] & {4{gnt_onehot_s[i]}});
            win_data_s = win_data_s | (req_data[DATA_W*i +: DATA_W] & {DATA_W{gnt_onehot_s[i]}});
        end
    end

    // Acceptance is a same-cycle handshake, so it is held off while reset is applied.
    assign accept_s = (state_q == ST_IDLE) & disp_ready & any_s & ~rst;

    // Next-state logic for the FSM, output registers and watchdog.
    always_comb begin
        state_d     = state_q;
        disp_cmd_d  = 4'd0;
        disp_data_d = disp_data_q;
        grant_d     = grant_q;
        req_ready_s = '0;
`ifdef DISPLAY_ARB_WATCHDOG_EN
        wd_d        = wd_q;
        err_d       = err_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (accept_s) begin
                    req_ready_s = gnt_onehot_s;
                    grant_d     = gnt_idx_s;
                    if (cmd_is_issuable(win_cmd_s)) begin
                        state_d     = ST_ISSUE;
                        disp_cmd_d  = win_cmd_s;
                        disp_data_d = win_data_s;
                    end else begin
                        state_d = ST_IDLE;
                    end
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                state_d = ST_GUARD;
            end
            ST_GUARD: begin
                // The engine may not have dropped disp_ready yet, so it is ignored here.
                state_d = ST_WAIT;
`ifdef DISPLAY_ARB_WATCHDOG_EN
                wd_d    = '0;
`endif
            end
            ST_WAIT: begin
                if (disp_ready) begin
                    state_d = ST_IDLE;
`ifdef DISPLAY_ARB_WATCHDOG_EN
                end else if (wd_q == WD_LAST) begin
                    state_d = ST_IDLE;
                    err_d   = 1'b1;
                end else begin
                    state_d = ST_WAIT;
                    wd_d    = wd_q + WD_W'(1);
                end
`else
                end else begin
                    state_d = ST_WAIT;
                end
`endif
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and output registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q     <= ST_IDLE;
            disp_cmd_q  <= 4'd0;
            disp_data_q <= '0;
            grant_q     <= IDX_W'(N_REQ - 1);
`ifdef DISPLAY_ARB_WATCHDOG_EN
            wd_q        <= '0;
            err_q       <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            disp_cmd_q  <= disp_cmd_d;
            disp_data_q <= disp_data_d;
            grant_q     <= grant_d;
`ifdef DISPLAY_ARB_WATCHDOG_EN
            wd_q        <= wd_d;
            err_q       <= err_d;
`endif
        end
    end

    assign req_ready = req_ready_s;
    assign disp_cmd  = disp_cmd_q;
    assign disp_data = disp_data_q;
    assign grant_id  = grant_q;
    assign busy      = (state_q != ST_IDLE);
`ifdef DISPLAY_ARB_WATCHDOG_EN
    assign timeout_err = err_q;
`else
    assign timeout_err = 1'b0;
`endif

endmodule

// File: tb/tb_display_cmd_arbiter.sv
// Directed self-checking bench for display_cmd_arbiter (4 requesters, 48-bit payload).
module tb_display_cmd_arbiter;

    localparam int N  = 4;
    localparam int DW = 48;

    logic              clk = 1'b0;
    logic              rst;
    logic [N-1:0]      req_valid;
    logic [4*N-1:0]    req_cmd;
    logic [DW*N-1:0]   req_data;
    logic [N-1:0]      req_ready;
    logic [3:0]        disp_cmd;
    logic [DW-1:0]     disp_data;
    logic              disp_ready;
    logic              busy;
    logic [1:0]        grant_id;
    logic              timeout_err;

    int n_checks = 0;
    int n_errors = 0;

    display_cmd_arbiter #(.N_REQ(N), .DATA_W(DW), .TIMEOUT(16)) dut (
        .clk         (clk),
        .rst         (rst),
        .req_valid   (req_valid),
        .req_cmd     (req_cmd),
        .req_data    (req_data),
        .req_ready   (req_ready),
        .disp_cmd    (disp_cmd),
        .disp_data   (disp_data),
        .disp_ready  (disp_ready),
        .busy        (busy),
        .grant_id    (grant_id),
        .timeout_err (timeout_err)
    );

    always #5 clk = ~clk;

    task automatic check_eq(input string tag, input logic [63:0] actual, input logic [63:0] expected);
        n_checks++;
        if (actual !== expected) begin
            n_errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", tag, actual, expected);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic settle();
        #1;
    endtask

    task automatic set_req(input int i, input logic [3:0] cmd, input logic [DW-1:0] data);
        req_cmd[4*i +: 4]    = cmd;
        req_data[DW*i +: DW] = data;
    endtask

    task automatic do_reset();
        rst        = 1'b1;
        req_valid  = '0;
        disp_ready = 1'b1;
        next_cycle();
        next_cycle();
        rst        = 1'b0;
    endtask

    int g_idx [8];
    int g_cyc [8];
    int n_grants;
    int width_bad;
    int bad;
    logic prev_nz;

    initial begin
        rst        = 1'b1;
        req_valid  = 4'b0011;
        req_cmd    = '0;
        req_data   = '0;
        disp_ready = 1'b1;
        for (int i = 0; i < N; i++) set_req(i, 4'd1, DW'(48'h1000 + i));
        next_cycle();
        next_cycle();
        settle();
        check_eq("rst_req_ready",   64'(req_ready),   64'h0);
        check_eq("rst_disp_cmd",    64'(disp_cmd),    64'h0);
        check_eq("rst_disp_data",   64'(disp_data),   64'h0);
        check_eq("rst_busy",        64'(busy),        64'h0);
        check_eq("rst_grant_id",    64'(grant_id),    64'h3);
        check_eq("rst_timeout_err", 64'(timeout_err), 64'h0);

        // Single request from requester 0, then the engine stays busy for 200 cycles
        rst       = 1'b0;
        req_valid = 4'b0001;
        set_req(0, 4'd3, 48'h05_0A00_0000_2A);
        settle();
        check_eq("single_ready_T", 64'(req_ready), 64'h1);
        check_eq("single_busy_T",  64'(busy),      64'h0);
        next_cycle();
        req_valid  = '0;
        disp_ready = 1'b0;
        settle();
        check_eq("single_cmd_T1",   64'(disp_cmd),  64'h3);
        check_eq("single_data_T1",  64'(disp_data), 64'h05_0A00_0000_2A);
        check_eq("single_busy_T1",  64'(busy),      64'h1);
        check_eq("single_grant_T1", 64'(grant_id),  64'h0);
        next_cycle();
        settle();
        check_eq("single_cmd_T2",  64'(disp_cmd),  64'h0);
        check_eq("single_data_T2", 64'(disp_data), 64'h05_0A00_0000_2A);
        req_valid = 4'b1111;
        bad = 0;
        for (int c = 0; c < 200; c++) begin
            next_cycle();
            settle();
            if (req_ready != 4'b0000 || disp_cmd != 4'd0 || busy != 1'b1) bad++;
        end
        check_eq("busy_window_violations", 64'(bad), 64'h0);
        next_cycle();
        disp_ready = 1'b1;
        settle();
        check_eq("wait_exit_no_grant", 64'(req_ready), 64'h0);
        check_eq("wait_exit_busy",     64'(busy),      64'h1);
        next_cycle();
        settle();
        check_eq("after_wait_busy",  64'(busy),      64'h0);
        check_eq("after_wait_ready", 64'(req_ready), 64'h2);

        // Requester 1 is in flight; reset during WAIT aborts it
        next_cycle();
        req_valid  = '0;
        disp_ready = 1'b0;
        settle();
        check_eq("r1_issue_cmd", 64'(disp_cmd), 64'h1);
        check_eq("r1_grant",     64'(grant_id), 64'h1);
        next_cycle();
        next_cycle();
        next_cycle();
        req_valid = 4'b0010;
        settle();
        check_eq("r1_wait_busy", 64'(busy), 64'h1);
        rst = 1'b1;
        settle();
        check_eq("midrst_req_ready", 64'(req_ready), 64'h0);
        check_eq("midrst_disp_cmd",  64'(disp_cmd),  64'h0);
        check_eq("midrst_disp_data", 64'(disp_data), 64'h0);
        check_eq("midrst_busy",      64'(busy),      64'h0);
        check_eq("midrst_grant_id",  64'(grant_id),  64'h3);
        next_cycle();
        rst        = 1'b0;
        req_valid  = 4'b0011;
        disp_ready = 1'b1;
        set_req(0, 4'd2, 48'hABCD_EF01_2345);
        settle();
        check_eq("postrst_r0_wins", 64'(req_ready), 64'h1);
        next_cycle();
        req_valid = '0;
        settle();
        check_eq("postrst_cmd",  64'(disp_cmd),  64'h2);
        check_eq("postrst_data", 64'(disp_data), 64'hABCD_EF01_2345);

        // Fairness: all four valid with cmd=1; engine ready whenever disp_cmd is 0
        do_reset();
        for (int i = 0; i < N; i++) set_req(i, 4'd1, DW'(48'h2000 + i));
        req_valid = 4'b1111;
        n_grants  = 0;
        width_bad = 0;
        prev_nz   = 1'b0;
        for (int k = 0; k < 8; k++) begin
            g_idx[k] = 15;
            g_cyc[k] = -1;
        end
        for (int c = 0; c < 40; c++) begin
            disp_ready = (disp_cmd == 4'd0);
            settle();
            if (req_ready != 4'b0000 && n_grants < 8) begin
                for (int k = 0; k < N; k++) begin
                    if (req_ready[k]) g_idx[n_grants] = k;
                end
                if ($countones(req_ready) != 1) g_idx[n_grants] = 14;
                g_cyc[n_grants] = c;
                n_grants++;
            end
            if (disp_cmd != 4'd0 && prev_nz) width_bad++;
            prev_nz = (disp_cmd != 4'd0);
            next_cycle();
        end
        req_valid = '0;
        check_eq("fair_grant0", 64'(g_idx[0]), 64'd0);
        check_eq("fair_grant1", 64'(g_idx[1]), 64'd1);
        check_eq("fair_grant2", 64'(g_idx[2]), 64'd2);
        check_eq("fair_grant3", 64'(g_idx[3]), 64'd3);
        check_eq("fair_grant4", 64'(g_idx[4]), 64'd0);
        check_eq("fair_gap",    64'(g_cyc[1] - g_cyc[0]), 64'd4);
        check_eq("fair_pulse_width_violations", 64'(width_bad), 64'h0);

        // Illegal opcodes are consumed and dropped
        do_reset();
        set_req(2, 4'd7, 48'h777);
        req_valid = 4'b0100;
        settle();
        check_eq("illegal_ready", 64'(req_ready), 64'h4);
        next_cycle();
        req_valid = '0;
        settle();
        check_eq("illegal_cmd",   64'(disp_cmd),  64'h0);
        check_eq("illegal_busy",  64'(busy),      64'h0);
        check_eq("illegal_grant", 64'(grant_id),  64'h2);
        check_eq("illegal_data",  64'(disp_data), 64'h0);
        set_req(3, 4'd0, 48'h333);
        req_valid = 4'b1000;
        settle();
        check_eq("nop_ready", 64'(req_ready), 64'h8);
        next_cycle();
        req_valid = '0;
        settle();
        check_eq("nop_grant", 64'(grant_id), 64'h3);
        check_eq("nop_busy",  64'(busy),     64'h0);

        // Engine never returns ready after an issue
        set_req(0, 4'd2, 48'h123);
        req_valid = 4'b0001;
        settle();
        check_eq("stuck_accept", 64'(req_ready), 64'h1);
        next_cycle();
        req_valid  = '0;
        disp_ready = 1'b0;
        repeat (17) next_cycle();
        settle();
        check_eq("stuck_busy_T18", 64'(busy),        64'h1);
        check_eq("stuck_err_T18",  64'(timeout_err), 64'h0);
        next_cycle();
        settle();
`ifdef DISPLAY_ARB_WATCHDOG_EN
        check_eq("wd_busy_T19", 64'(busy),        64'h0);
        check_eq("wd_err_T19",  64'(timeout_err), 64'h1);
        repeat (3) next_cycle();
        settle();
        check_eq("wd_err_sticky", 64'(timeout_err), 64'h1);
        do_reset();
        settle();
        check_eq("wd_err_cleared", 64'(timeout_err), 64'h0);
`else
        check_eq("nowd_busy_T19", 64'(busy),        64'h1);
        check_eq("nowd_err_T19",  64'(timeout_err), 64'h0);
`endif

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
